// File: rtl/byte_arb_pkg.sv
// byte_arb_pkg: shared bus types, FSM state encoding and counter width for the byte arbiter.
package byte_arb_pkg;
    typedef byte byte_t;
    typedef byte_t beat_t;
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    localparam int BEAT_CNT_W = 8;
endpackage

// File: rtl/byte_rr_pick.sv
// byte_rr_pick: first set request at or after ptr, wrapping, via a doubled-vector priority scan.
module byte_rr_pick
    import byte_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    logic [N_REQ-1:0] rot;
    assign rot = N_REQ'({req, req} >> ptr);
    // Scan downwards so the lowest rotated position (closest to ptr) wins.
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                idx = IDX_W'((int'(ptr) + i) % N_REQ);
            end
        end
    end
endmodule

// File: rtl/byte_rr_arbiter.sv
// byte_rr_arbiter: round-robin burst arbiter sharing one byte bus among N_REQ requesters.
// Define BYTE_ARB_TIMEOUT_EN to add a stall counter that forces release and pulses timeout.
module byte_rr_arbiter
    import byte_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int BURST_MAX = 4,
    parameter int TIMEOUT = 16,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_REQ-1:0]                      req,
    input  logic [N_REQ-1:0]                      last,
    input  logic [N_REQ-1:0][$bits(byte_t)-1:0]   data_in,
    output logic [N_REQ-1:0]                      gnt,
    output logic                                  bus_valid,
    output beat_t                                 bus_data,
    input  logic                                  bus_ready,
    output logic [IDX_W-1:0]                      owner,
    output logic                                  busy
`ifdef BYTE_ARB_TIMEOUT_EN
   ,output logic                                  timeout
`endif
);
    state_t                state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      pick;
    logic                  found;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic                  xfer;
    logic                  done;
    logic                  to_hit;

    byte_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (pick)
    );

    assign busy      = state == GRANT;
    assign bus_valid = busy && req[owner];
    assign bus_data  = busy ? beat_t'(data_in[owner]) : beat_t'(0);
    assign xfer      = bus_valid && bus_ready;
    assign done      = !req[owner] || to_hit
                     || (xfer && (last[owner] || beat_cnt == BEAT_CNT_W'(BURST_MAX - 1)));

`ifdef BYTE_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_cnt;
    logic               stall;
    assign stall  = bus_valid && !bus_ready;
    assign to_hit = stall && stall_cnt == STALL_W'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (!rst_n || !busy || xfer || to_hit)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= stall_cnt + 1'b1;
        timeout <= rst_n && to_hit;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    state <= GRANT;
                    gnt   <= N_REQ'(1) << pick;
                    owner <= pick;
                end
                GRANT: begin
                    if (xfer && beat_cnt != BEAT_CNT_W'(BURST_MAX))
                        beat_cnt <= beat_cnt + 1'b1;
                    if (done) begin
                        state <= RELEASE;
                        gnt   <= '0;
                    end
                end
                RELEASE: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                    rr_ptr   <= owner == IDX_W'(N_REQ - 1) ? '0 : owner + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always @* begin
        assert ($onehot0(gnt));
        assert (!bus_valid || busy);
        assert ($bits(bus_data) == 8);
        assert (TIMEOUT >= 1);
    end
endmodule
